// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz,
  output logic             err
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_n;
  logic is_mul, is_div, is_mt, sgn, sa, sb, accept, last, ge;
  logic div_q, neg_q, rneg_q, bz_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, qr, m, acc_n, qr_n, abs_a, abs_b;
  logic [WIDTH:0] sum, sh;
  logic [2*WIDTH-1:0] prod;
  assign is_mul = op == 6'h18 || op == 6'h19;
  assign is_div = op == 6'h1A || op == 6'h1B;
  assign is_mt = op == 6'h11 || op == 6'h13;
  assign sgn = op == 6'h18 || op == 6'h1A;
  assign sa = sgn & a[WIDTH-1];
  assign sb = sgn & b[WIDTH-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;
  assign accept = start && state == IDLE;
  assign last = cnt == CNT_W'(WIDTH - 1);
  assign busy = state == CALC;
  // multiply shifts {acc,qr} right after a conditional add; divide shifts left with a restoring subtract
  assign sum = {1'b0, acc} + {1'b0, qr[0] ? m : '0};
  assign sh = {acc, qr[WIDTH-1]};
  assign ge = sh >= {1'b0, m};
  assign acc_n = div_q ? (ge ? WIDTH'(sh - {1'b0, m}) : sh[WIDTH-1:0]) : sum[WIDTH:1];
  assign qr_n = div_q ? {qr[WIDTH-2:0], ge} : {sum[0], qr[WIDTH-1:1]};
  assign prod = {acc_n, qr_n};
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = accept && (is_mul || is_div) ? CALC : IDLE;
    else state_n = last ? IDLE : CALC;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      err <= 1'b0;
      dbz <= 1'b0;
      hi <= '0;
      lo <= '0;
      acc <= '0;
      qr <= '0;
      m <= '0;
      cnt <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      bz_q <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      if (accept) begin
        if (is_mul || is_div) begin
          div_q <= is_div;
          neg_q <= sa ^ sb;
          rneg_q <= sa;
          bz_q <= b == '0;
          acc <= '0;
          qr <= is_div ? abs_a : abs_b;
          m <= is_div ? abs_b : abs_a;
          cnt <= '0;
        end else if (is_mt) begin
          if (op == 6'h11) hi <= a;
          else lo <= a;
          done <= 1'b1;
        end else err <= 1'b1;
      end else if (state == CALC) begin
        acc <= acc_n;
        qr <= qr_n;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          done <= 1'b1;
          if (div_q) begin
            lo <= neg_q ? -qr_n : qr_n;
            hi <= rneg_q ? -acc_n : acc_n;
            dbz <= bz_q;
          end else {hi, lo} <= neg_q ? -prod : prod;
        end
      end
    end
  end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: directed checks of the multiply/divide unit at WIDTH=32 and WIDTH=8
module tb_mips_muldiv_unit;
  logic clk, rst_n, start, busy, done, dbz, err;
  logic [5:0] op;
  logic [31:0] a, b, hi, lo;
  logic start8, busy8, done8, dbz8, err8;
  logic [5:0] op8;
  logic [7:0] a8, b8, hi8, lo8;
  int tests = 0, fails = 0;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbz(dbz), .err(err));

  mips_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .dbz(dbz8), .err(err8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // called at posedge+1; returns edges after E0 until done (-1 on timeout) and busy-sampled cycles
  task automatic do_op(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bc);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; bc = busy ? 1 : 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (busy) bc++;
    end
    lat = done ? n : -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, dbz, err} !== 4'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b dbz=%b err=%b hi=%h lo=%h, want all 0", busy, done, dbz, err, hi, lo);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu;
    int lat, bc;
    do_op(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    tests++;
    if (lat !== 32 || bc !== 32) begin
      fails++;
      $display("FAIL multu_latency: lat=%0d busy_cycles=%0d, want 32/32", lat, bc);
    end
    tests++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001 || busy !== 1'b0) begin
      fails++;
      $display("FAIL multu_result: hi=%h lo=%h busy=%b, want fffffffe 00000001 0", hi, lo, busy);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    do_op(6'h18, 32'hFFFFFFFD, 32'd5, lat, bc);
    tests++;
    if (lat !== 32 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      fails++;
      $display("FAIL mult_signed: lat=%0d hi=%h lo=%h, want 32 ffffffff fffffff1", lat, hi, lo);
    end
    do_op(6'h1A, 32'hFFFFFFF9, 32'd2, lat, bc);
    tests++;
    if (lat !== 32 || bc !== 32 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL b2b_div: lat=%0d bc=%0d lo=%h hi=%h, want 32 32 fffffffd ffffffff", lat, bc, lo, hi);
    end
  endtask

  task automatic test_divide;
    int lat, bc;
    do_op(6'h1B, 32'd100, 32'd0, lat, bc);
    tests++;
    if (lat !== 32 || lo !== 32'hFFFFFFFF || hi !== 32'h64 || dbz !== 1'b1) begin
      fails++;
      $display("FAIL divu_by_zero: lat=%0d lo=%h hi=%h dbz=%b, want 32 ffffffff 64 1", lat, lo, hi, dbz);
    end
    do_op(6'h18, 32'd2, 32'd3, lat, bc);
    tests++;
    if (lo !== 32'd6 || hi !== 32'd0 || dbz !== 1'b1) begin
      fails++;
      $display("FAIL mult_keeps_dbz: lo=%h hi=%h dbz=%b, want 6 0 1", lo, hi, dbz);
    end
    do_op(6'h1B, 32'd100, 32'd7, lat, bc);
    tests++;
    if (lo !== 32'd14 || hi !== 32'd2 || dbz !== 1'b0) begin
      fails++;
      $display("FAIL divu: lo=%h hi=%h dbz=%b, want e 2 0", lo, hi, dbz);
    end
    do_op(6'h1A, 32'hFFFFFF9C, 32'd0, lat, bc);
    tests++;
    if (lo !== 32'd1 || hi !== 32'hFFFFFF9C || dbz !== 1'b1) begin
      fails++;
      $display("FAIL div_neg_by_zero: lo=%h hi=%h dbz=%b, want 1 ffffff9c 1", lo, hi, dbz);
    end
    do_op(6'h1A, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    tests++;
    if (lo !== 32'h80000000 || hi !== 32'h0 || dbz !== 1'b0) begin
      fails++;
      $display("FAIL div_min_neg1: lo=%h hi=%h dbz=%b, want 80000000 0 0", lo, hi, dbz);
    end
  endtask

  task automatic test_mt_err;
    int lat, bc;
    do_op(6'h11, 32'h12345678, 32'h0, lat, bc);
    tests++;
    if (lat !== 0 || bc !== 0 || hi !== 32'h12345678 || lo !== 32'h80000000) begin
      fails++;
      $display("FAIL mthi: lat=%0d bc=%0d hi=%h lo=%h, want 0 0 12345678 80000000", lat, bc, hi, lo);
    end
    do_op(6'h13, 32'hCAFEBABE, 32'h0, lat, bc);
    tests++;
    if (lat !== 0 || bc !== 0 || hi !== 32'h12345678 || lo !== 32'hCAFEBABE || dbz !== 1'b0) begin
      fails++;
      $display("FAIL mtlo: lat=%0d bc=%0d hi=%h lo=%h dbz=%b, want 0 0 12345678 cafebabe 0", lat, bc, hi, lo, dbz);
    end
    start = 1'b1; op = 6'h20; a = 32'h1111; b = 32'h2222;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'hCAFEBABE) begin
      fails++;
      $display("FAIL illegal_op: err=%b done=%b busy=%b hi=%h lo=%h, want 1 0 0 12345678 cafebabe", err, done, busy, hi, lo);
    end
    @(posedge clk); #1;
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse: err=%b, want 0", err);
    end
  endtask

  task automatic test_ignore_start;
    int ndone = 0, lat = -1;
    logic [31:0] qh = '0, ql = '0;
    start = 1'b1; op = 6'h1B; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin start = 1'b1; op = 6'h19; a = 32'd3; b = 32'd5; end
      if (k == 6) begin start = 1'b0; a = 32'hDEAD; b = 32'hBEEF; end
      if (done) begin ndone++; lat = k; qh = hi; ql = lo; end
    end
    tests++;
    if (ndone !== 1 || lat !== 32 || ql !== 32'd142 || qh !== 32'd6) begin
      fails++;
      $display("FAIL ignore_start: dones=%0d lat=%0d lo=%h hi=%h, want 1 32 8e 6", ndone, lat, ql, qh);
    end
  endtask

  task automatic test_async_reset;
    int lat, bc, ndone = 0;
    do_op(6'h1B, 32'd5, 32'd0, lat, bc);
    start = 1'b1; op = 6'h18; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, dbz} !== 3'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: busy=%b done=%b dbz=%b hi=%h lo=%h, want all 0", busy, done, dbz, hi, lo);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    tests++;
    if (ndone !== 0) begin
      fails++;
      $display("FAIL reset_abort: %0d cycles with done/busy after release, want 0", ndone);
    end
  endtask

  task automatic test_width8;
    int n = 0, bc = 0;
    start8 = 1'b1; op8 = 6'h19; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    if (busy8) bc++;
    while (!done8 && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (busy8) bc++;
    end
    tests++;
    if (n !== 8 || bc !== 8 || hi8 !== 8'hFE || lo8 !== 8'h01) begin
      fails++;
      $display("FAIL w8_multu: lat=%0d bc=%0d hi=%h lo=%h, want 8 8 fe 01", n, bc, hi8, lo8);
    end
    start8 = 1'b1; op8 = 6'h1A; a8 = 8'h80; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n !== 8 || hi8 !== 8'h00 || lo8 !== 8'h80 || dbz8 !== 1'b0) begin
      fails++;
      $display("FAIL w8_div_min: lat=%0d hi=%h lo=%h dbz=%b, want 8 00 80 0", n, hi8, lo8, dbz8);
    end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_back_to_back;
    test_divide;
    test_mt_err;
    test_ignore_start;
    test_async_reset;
    test_width8;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit that sits beside the MIPS ALU in the execute stage. It implements the MIPS R-type function codes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results are held in internal HI/LO registers that are always visible on output ports for MFHI/MFLO. It is a multi-cycle block with a start/busy/done handshake, in place of a single-cycle combinational datapath.

Parameters:
WIDTH, 32, operand, HI and LO width in bits (minimum 4).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
op  input  6  MIPS function code: 6'h18 MULT, 6'h19 MULTU, 6'h1A DIV, 6'h1B DIVU, 6'h11 MTHI, 6'h13 MTLO
a  input  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source)
b  input  WIDTH  rt operand (multiplier/divisor)
busy  output  1  high while an iterative operation is in progress
done  output  1  one-cycle pulse when HI/LO have been updated
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
dbz  output  1  divide-by-zero flag for the last DIV/DIVU
err  output  1  one-cycle pulse on an illegal op accepted with start

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, err=0, dbz=0, hi=0, lo=0, counter=0. Reset mid-operation aborts the operation with no partial result.
- States:
  - IDLE: start=1 at edge E0 with a legal op latches op, |a| and |b| (for signed ops), the result signs and the divisor-zero flag. Next state is CALC for MULT/MULTU/DIV/DIVU.
  - CALC: one shift-add (multiply) or restoring-subtract (divide) step per cycle, exactly WIDTH cycles. Then return to IDLE and write HI/LO.
- Latency: busy=1 from after E0 until edge E0+WIDTH. At that edge hi/lo update, busy falls, done=1 for exactly one cycle.
- A start asserted in the cycle done is high is accepted (back-to-back, no bubble).
- start while busy=1 is ignored. No queuing, no effect on the operation in flight.
- MTHI/MTLO: at E0 a is written to hi or lo respectively. The other register is unchanged. done=1 for the following cycle. busy stays 0 and dbz is unchanged.
- Illegal op with start in IDLE: err=1 for one cycle. hi, lo, dbz, busy and done are unchanged.
- Multiply: the 2*WIDTH-bit product goes to {hi,lo}.
  - MULTU is unsigned.
  - MULT computes on magnitudes and two's-complement negates the product if sign(a)^sign(b).
  - No overflow is possible.
- Divide: lo=quotient, hi=remainder.
  - Signed quotient sign is sign(a)^sign(b). Remainder sign is sign(a) (truncation toward zero).
  - Signed MIN / -1 gives lo=MIN, hi=0, with no flag.
- Divide by zero (b=0, DIV or DIVU): still takes WIDTH cycles.
  - DIVU result: lo=all ones, hi=a.
  - DIV result: hi=a. lo is 1 (all zeros + 1) if a is negative, otherwise all ones.
  - dbz=1 from the result edge until the next completed DIV/DIVU or reset.
- dbz is cleared at the result edge of any DIV/DIVU with b≠0. MULT/MULTU leave dbz unchanged.
- hi/lo change only at the result/MT* edges and hold otherwise.
- Operands a/b may change after E0 without affecting the result.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for exactly 32 cycles; done pulse; hi=0xFFFFFFFE lo=0x00000001.
- MULT a=-3 (0xFFFFFFFD) b=5, then back-to-back start on the done cycle with DIV a=-7 b=2 -> first result hi=0xFFFFFFFF lo=0xFFFFFFF1; second result lo=0xFFFFFFFD hi=0xFFFFFFFF, 32 cycles later, no idle bubble.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF hi=0x64 dbz=1; then DIVU a=100 b=7 -> lo=14 hi=2 dbz=0. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0 dbz=0.
- MTHI a=0x12345678 then MTLO a=0xCAFEBABE -> each done after 1 cycle, busy never high; hi=0x12345678 lo=0xCAFEBABE. op=6'h20 with start -> err pulse; hi/lo unchanged.
- During DIVU, pulse start with MULTU and toggle a/b mid-operation -> ignored; original quotient produced; exactly one done.
- Assert rst_n=0 asynchronously (between clock edges) 10 cycles into MULT -> busy/done/hi/lo/dbz go to 0 immediately; no done after release. Repeat the first scenario with WIDTH=8: 0xFF*0xFF -> hi=0xFE lo=0x01 after 8 cycles.
